// File: rtl/sync_fifo.sv
// Single-clock byte FIFO with registered read data.
// Status flags are decoded from a registered occupancy count, so they never
// depend combinationally on the r/w strobes.
module sync_fifo #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  r,
  input  logic                  w,
  input  logic [DATA_WIDTH-1:0] din,
  output logic                  is_empty,
  output logic                  is_full,
  output logic [DATA_WIDTH-1:0] dout
);

  localparam logic [ADDR_WIDTH:0] FULL_COUNT = {1'b1, {ADDR_WIDTH{1'b0}}};

  logic [DATA_WIDTH-1:0] mem [0:(1 << ADDR_WIDTH)-1];
  logic [ADDR_WIDTH-1:0] wptr;
  logic [ADDR_WIDTH-1:0] rptr;
  logic [ADDR_WIDTH:0]   count;

  logic do_read;
  logic do_write;

  // Accept decisions: a full FIFO still takes a write when a read frees a slot
  // in the same cycle; an empty FIFO never reads, even if a write arrives.
  always_comb begin
    do_read  = r && !is_empty;
    do_write = w && (!is_full || do_read);
  end

  // Flags decoded from the registered count.
  always_comb begin
    is_empty = (count == '0);
    is_full  = (count == FULL_COUNT);
  end

  // Storage array; contents are not reset.
  always_ff @(posedge clk) begin
    if (reset && do_write) begin
      mem[wptr] <= din;
    end
  end

  // Pointers, occupancy count and registered read data.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      dout  <= '0;
    end else begin
      if (do_write) begin
        wptr <= wptr + 1'b1;
      end
      if (do_read) begin
        rptr <= rptr + 1'b1;
        dout <= mem[rptr];
      end
      case ({do_write, do_read})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_sync_fifo.sv
// Directed testbench for sync_fifo with hand-computed expected values.
module tb_sync_fifo;

  logic       clk;
  logic       reset;
  logic       r;
  logic       w;
  logic [7:0] din;
  logic       is_empty;
  logic       is_full;
  logic [7:0] dout;

  int tests;
  int fails;

  sync_fifo #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) dut (
    .clk      (clk),
    .reset    (reset),
    .r        (r),
    .w        (w),
    .din      (din),
    .is_empty (is_empty),
    .is_full  (is_full),
    .dout     (dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] v);
    w = 1'b1; r = 1'b0; din = v;
    tick();
    w = 1'b0;
  endtask

  task automatic pop_check(input string tag, input logic [7:0] exp);
    r = 1'b1; w = 1'b0;
    tick();
    r = 1'b0;
    check(tag, dout, exp);
  endtask

  initial begin
    tests = 0;
    fails = 0;
    reset = 1'b0; r = 1'b0; w = 1'b0; din = '0;

    // 1: reset
    for (int i = 0; i < 10; i++) tick();
    check("rst_empty", is_empty, 1);
    check("rst_full",  is_full,  0);
    check("rst_dout",  dout,     0);
    reset = 1'b1;

    // 2: four writes, two reads
    push(8'd26); push(8'd33); push(8'd45); push(8'd112);
    check("t2_not_empty_after_writes", is_empty, 0);
    pop_check("t2_rd0", 8'd26);
    pop_check("t2_rd1", 8'd33);
    check("t2_not_empty", is_empty, 0);

    // 3: simultaneous r/w in the middle, then drain
    r = 1'b1; w = 1'b1; din = 8'd233;
    tick();
    r = 1'b0; w = 1'b0;
    check("t3_rw_dout", dout, 45);
    check("t3_rw_not_empty", is_empty, 0);
    check("t3_rw_not_full", is_full, 0);
    pop_check("t3_rd112", 8'd112);
    check("t3_not_empty_1left", is_empty, 0);
    pop_check("t3_rd233", 8'd233);
    check("t3_empty", is_empty, 1);
    pop_check("t3_empty_read_holds", 8'd233);
    check("t3_still_empty", is_empty, 1);
    // r=w=1 while empty: only the write happens, dout holds
    r = 1'b1; w = 1'b1; din = 8'd55;
    tick();
    r = 1'b0; w = 1'b0;
    check("t3_empty_rw_dout_holds", dout, 233);
    check("t3_empty_rw_not_empty", is_empty, 0);
    pop_check("t3_empty_rw_data", 8'd55);
    check("t3_empty_again", is_empty, 1);

    // 4: fill to full, overflow write ignored, drain
    for (int i = 0; i < 15; i++) push(8'(i));
    check("t4_not_full_15", is_full, 0);
    push(8'd15);
    check("t4_full_16", is_full, 1);
    push(8'd99);
    check("t4_full_after_overflow", is_full, 1);
    for (int i = 0; i < 16; i++) begin
      pop_check($sformatf("t4_rd%0d", i), 8'(i));
      if (i == 0) check("t4_not_full_after_pop", is_full, 0);
    end
    check("t4_empty", is_empty, 1);
    pop_check("t4_empty_read_holds", 8'd15);

    // 5: wrap-around, 10 rounds of 3 writes then 3 reads
    for (int round = 0; round < 10; round++) begin
      for (int k = 0; k < 3; k++) push(8'(round * 3 + k + 1));
      for (int k = 0; k < 3; k++)
        pop_check($sformatf("t5_rd%0d", round * 3 + k + 1), 8'(round * 3 + k + 1));
    end
    check("t5_empty", is_empty, 1);

    // 6: full with simultaneous r/w
    for (int i = 0; i < 16; i++) push(8'(100 + i));
    check("t6_full", is_full, 1);
    r = 1'b1; w = 1'b1; din = 8'd200;
    tick();
    r = 1'b0; w = 1'b0;
    check("t6_rw_dout_oldest", dout, 100);
    check("t6_rw_still_full", is_full, 1);
    for (int i = 1; i < 16; i++) pop_check($sformatf("t6_rd%0d", 100 + i), 8'(100 + i));
    pop_check("t6_rd200_last", 8'd200);
    check("t6_empty", is_empty, 1);

    // 6b: reset in the middle of a read/write burst
    for (int i = 0; i < 8; i++) push(8'(40 + i));
    pop_check("t6b_rd40", 8'd40);
    pop_check("t6b_rd41", 8'd41);
    r = 1'b1; w = 1'b1; din = 8'd7; reset = 1'b0;
    tick();
    check("t6b_rst_empty", is_empty, 1);
    check("t6b_rst_full",  is_full,  0);
    check("t6b_rst_dout",  dout,     0);
    r = 1'b0; w = 1'b0; reset = 1'b1;
    push(8'd77);
    pop_check("t6b_after_rst", 8'd77);
    check("t6b_after_rst_empty", is_empty, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/sync_fifo.md
Name: sync_fifo

Overview:
- Single-clock, synchronous first-in-first-out byte buffer with registered read data and full/empty status flags.
- Decouples a producer and a consumer that share one clock inside the hub datapath.
- Writes and reads use independent single-cycle strobes; the same cycle may carry both.

Parameters:
- DATA_WIDTH, 8, width of each stored word (din/dout).
- ADDR_WIDTH, 4, pointer width; depth = 2**ADDR_WIDTH (16 entries by default).

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- reset  input  1  synchronous, active-low reset (0 = reset asserted, sampled on rising clk).
- r  input  1  read strobe; pops one word per clock while high.
- w  input  1  write strobe; pushes din per clock while high.
- din  input  DATA_WIDTH  write data, sampled on rising clk when w=1.
- is_empty  output  1  high when the FIFO holds 0 words.
- is_full  output  1  high when the FIFO holds 2**ADDR_WIDTH words.
- dout  output  DATA_WIDTH  registered read data, i.e. the last word popped.

Behaviour:
- Storage: 2**ADDR_WIDTH x DATA_WIDTH register array, plus write pointer, read pointer and occupancy count (ADDR_WIDTH+1 bits). Flags are decoded from the count.
- Reset (reset=0 at a rising edge): pointers=0, count=0, dout=0, is_empty=1, is_full=0. Array contents are don't-care. Reset overrides r/w in the same cycle and aborts any in-progress traffic.
- Write (w=1, not full): mem[wptr]<=din; wptr<=wptr+1, wrapping modulo depth; count+1.
- Write while full (w=1, r=0): ignored. No pointer, count or data change.
- Read (r=1, not empty): dout<=mem[rptr]; rptr<=rptr+1 with wrap; count-1. dout is valid one edge after the strobe is sampled (1-cycle latency).
- Read while empty: ignored; dout holds its previous value.
- dout holds its value in every cycle without an accepted read.
- Simultaneous r=1, w=1:
  - Neither empty nor full: both operations happen; count unchanged.
  - Empty: only the write happens; dout holds; count becomes 1; is_empty falls after the edge.
  - Full: both the read and the write happen; the freed slot is written; count stays at full; is_full stays 1.
- Flags update on the same edge that changes the count (registered or decoded from the registered count). No combinational path from r/w to the flags.
- Pointer wrap-around is seamless: data order is preserved across the array boundary.
- Ordering: words exit in exactly the order they were accepted.

Test Plan:
1. Reset held low for 10 cycles -> is_empty=1, is_full=0, dout=0. Then release reset (set to 1).
2. Write 26, 33, 45, 112 on four consecutive cycles (w=1), then w=0 and r=1 for two cycles -> dout=26 after the first read edge and 33 after the second; is_empty=0 with 2 words left.
3. With 2 words left, drive r=1, w=1 with din=233 for one cycle -> dout=45; count stays 2. Drain with r=1 -> dout=112, then 233; is_empty=1. A further r=1 keeps dout=233.
4. From empty, write 16 words 0..15 -> is_full=1 after the 16th edge. A 17th write of 99 is ignored. Read all 16 -> dout sequence 0..15; is_empty=1 at the end.
5. Wrap-around: repeatedly write 3 and read 3 for 10 rounds with values 1..30 -> read order is exactly 1..30, with no loss or duplication across the pointer wrap.
6. Full with simultaneous r=w=1 (din=200) -> dout receives the oldest word, is_full stays 1, and 200 emerges last. Reset asserted mid-burst -> next edge shows is_empty=1 and dout=0.
